// File: rtl/jk_count_sequencer_pkg.sv
// Shared types and JK control codes for the JK-cell counter sequencer.
// The command, state and cell-control encodings live here so top and bench agree.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // A loaded bit is forced with set/clear so the cell ignores its old value.
  function automatic logic [1:0] jk_for_bit(input logic d);
    if (d) begin
      return JK_SET;
    end else begin
      return JK_CLR;
    end
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell, falling-edge clocked, asynchronously cleared.
module jk_cell (
  input  logic elk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // JK state update: hold / clear / set / toggle.
  always_ff @(negedge elk or negedge reset) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_count_sequencer.sv
// Command-driven sequencer for a WIDTH-bit counter made of JK cells.
// Accepts clear/load/up-to/down-to commands and pulses done with a wrap flag.
module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             elk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrapped
);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    wrap_q, wrap_d;
  logic                    ready_q, busy_q, done_q, wrapped_q;

  logic [WIDTH-1:0]        count_s;
  logic [WIDTH-1:0]        tog_s;
  logic [WIDTH-1:0]        next_s;
  logic                    dir_down_s;
  logic                    at_target_s;
  logic                    hit_s;
  logic                    wrap_step_s;
  logic [WIDTH-1:0][1:0]   jk_s;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .elk   (elk),
      .reset (reset),
      .j     (jk_s[gi][1]),
      .k     (jk_s[gi][0]),
      .q     (count_s[gi])
    );
  end

  assign dir_down_s  = (op_q == OP_DOWN);
  assign next_s      = count_s ^ tog_s;
  assign at_target_s = (count_s == data_q);
  assign hit_s       = (next_s == data_q);
  assign wrap_step_s = dir_down_s ? (count_s == {WIDTH{1'b0}}) : (count_s == {WIDTH{1'b1}});

  // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry;
    tog_s = {WIDTH{1'b0}};
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog_s[i] = carry;
      carry    = carry & (count_s[i] ^ dir_down_s);
    end
  end

  // Per-cell JK controls; every cell holds outside EXEC.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk_s[i] = JK_HOLD;
      if (state_q == S_EXEC) begin
        case (op_q)
          OP_CLEAR: jk_s[i] = JK_CLR;
          OP_LOAD:  jk_s[i] = jk_for_bit(data_q[i]);
          OP_UP, OP_DOWN: begin
            if (!at_target_s && tog_s[i]) begin
              jk_s[i] = JK_TOG;
            end else begin
              jk_s[i] = JK_HOLD;
            end
          end
          default:  jk_s[i] = JK_HOLD;
        endcase
      end else begin
        jk_s[i] = JK_HOLD;
      end
    end
  end

  // FSM next state, command latch and sticky wrap tracking.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          data_d  = cmd_data;
          wrap_d  = 1'b0;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        if ((op_q == OP_UP) || (op_q == OP_DOWN)) begin
          // Already at target means a zero-step command: one hold edge, then done.
          if (!at_target_s) begin
            if (wrap_step_s) begin
              wrap_d = 1'b1;
            end else begin
              wrap_d = wrap_q;
            end
            if (hit_s) begin
              state_d = S_DONE;
            end else begin
              state_d = S_EXEC;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latch and registered status outputs decoded from the next state.
  always_ff @(negedge elk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLEAR;
      data_q    <= {WIDTH{1'b0}};
      wrap_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      wrap_q    <= wrap_d;
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      wrapped_q <= (state_d == S_DONE) && wrap_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign count     = count_s;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Self-checking bench for jk_count_sequencer (WIDTH=4): directed plan plus random commands
// checked against an arithmetic model of the command semantics.
module tb_jk_count_sequencer;

  localparam int W = 4;
  localparam int M = 16;

  logic         elk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrapped;

  int tests_run;
  int tests_failed;
  int cur_model;

  jk_count_sequencer #(.WIDTH(W)) dut (
    .elk       (elk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped)
  );

  initial elk = 1'b1;
  always #5 elk = ~elk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE (called just after a rising edge) and check every cycle.
  task automatic run_cmd(input int op, input int data, input bit hold_next);
    int vals[$];
    int n;
    int d;
    bit wrap_exp;
    vals = {};
    wrap_exp = 1'b0;
    case (op)
      0: begin n = 1; vals.push_back(0); end
      1: begin n = 1; vals.push_back(data); end
      2: begin
        d = (data - cur_model + M) % M;
        if (d == 0) begin n = 1; vals.push_back(cur_model); end
        else begin
          n = d;
          for (int s = 1; s <= d; s++) vals.push_back((cur_model + s) % M);
          wrap_exp = (cur_model + d) > (M - 1);
        end
      end
      default: begin
        d = (cur_model - data + M) % M;
        if (d == 0) begin n = 1; vals.push_back(cur_model); end
        else begin
          n = d;
          for (int s = 1; s <= d; s++) vals.push_back((cur_model - s + M) % M);
          wrap_exp = (cur_model - d) < 0;
        end
      end
    endcase

    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_data  = W'(data);
    @(negedge elk);
    @(posedge elk);
    if (hold_next) begin
      cmd_op   = 2'd0;
      cmd_data = W'(9);
    end else begin
      cmd_valid = 1'b0;
    end
    chk("exec_entry_busy", 32'(busy), 32'd1);
    chk("exec_entry_ready", 32'(cmd_ready), 32'd0);
    chk("exec_entry_done", 32'(done), 32'd0);
    chk("exec_entry_count", 32'(count), 32'(cur_model));
    for (int s = 0; s < n; s++) begin
      @(negedge elk);
      @(posedge elk);
      chk("step_count", 32'(count), 32'(vals[s]));
      chk("step_busy", 32'(busy), 32'd1);
      chk("step_ready", 32'(cmd_ready), 32'd0);
      chk("step_done", 32'(done), (s == n - 1) ? 32'd1 : 32'd0);
      chk("step_wrapped", 32'(wrapped), (s == n - 1) ? 32'(wrap_exp) : 32'd0);
    end
    @(negedge elk);
    @(posedge elk);
    cur_model = vals[n - 1];
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_wrapped", 32'(wrapped), 32'd0);
    chk("idle_count", 32'(count), 32'(cur_model));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cur_model    = 0;
    reset        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_data     = '0;

    repeat (2) @(posedge elk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    reset = 1'b1;
    @(posedge elk);

    // Reset in the middle of an UP command.
    run_cmd(1, 3, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_data  = W'(12);
    @(negedge elk);
    @(posedge elk);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge elk);
      @(posedge elk);
    end
    chk("mid_up_count", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_done", 32'(done), 32'd0);
    @(posedge elk);
    reset = 1'b1;
    cur_model = 0;
    repeat (6) begin
      @(posedge elk);
      chk("post_rst_no_done", 32'(done), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
    end

    run_cmd(1, 10, 1'b0);   // LOAD 0xA
    run_cmd(1, 3, 1'b0);
    run_cmd(2, 7, 1'b0);    // UP 3 -> 7
    run_cmd(1, 14, 1'b0);
    run_cmd(2, 1, 1'b0);    // UP 14 -> 1, wraps
    run_cmd(3, 14, 1'b0);   // DOWN 1 -> 14, wraps
    run_cmd(1, 6, 1'b0);
    run_cmd(2, 6, 1'b0);    // zero-step UP
    run_cmd(3, 11, 1'b1);   // DOWN with a CLEAR held pending
    run_cmd(0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_count_sequencer.md
Name: jk_count_sequencer

Overview:
Command-driven controller that sequences a WIDTH-bit counter built from JK flip-flop cells. It accepts one command at a time over a valid/ready handshake and generates the per-bit {J,K} controls for the cells. Supported commands are clear, load, count up to a target, and count down to a target. It signals completion with a one-cycle done pulse and reports whether the count wrapped during the command.

Parameters:
WIDTH, 4, counter width in bits (min 2)

Ports:
elk  input  1  clock; all state changes on falling edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
cmd_data  input  WIDTH  load value (LOAD) or target count (UP/DOWN); ignored for CLEAR
count  output  WIDTH  current counter value (JK cell outputs)
busy  output  1  high in EXEC and DONE
done  output  1  one-cycle pulse when a command completes
wrapped  output  1  high with done if UP passed max->0 or DOWN passed 0->max during the command

Behaviour:
- Clocking and reset:
  - Single clock domain; every register updates on the negedge of elk.
  - reset low asynchronously forces: state=IDLE, count=0, cmd_ready=1, busy=0, done=0, wrapped=0, latched op/data=0.
  - Reset mid-command abandons the command; no done is issued.
- FSM states:
  - IDLE: cmd_ready=1. If cmd_valid is high at a falling edge, latch cmd_op and cmd_data, clear the wrap tracker, go to EXEC.
  - EXEC: cmd_ready=0, busy=1. Drives the JK controls for one step per edge.
  - DONE: busy=1, done=1 for exactly one cycle, then go to IDLE.
- cmd_valid while busy is ignored; the requester holds it until cmd_ready. A command may be accepted on the same edge that DONE returns to IDLE only if the FSM is already in IDLE at that edge, so accepts are never back-to-back closer than IDLE->EXEC->DONE->IDLE.
- JK cell encoding {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
- CLEAR: one EXEC edge with {J,K}=01 on all bits, so count=0; then DONE.
  - Timing: accept at edge k, count updated at edge k+1, done high between edges k+1 and k+2.
- LOAD: one EXEC edge with J=data[i], K=~data[i], so count=data; then DONE. Same timing as CLEAR.
- UP:
  - Each EXEC edge sets J=K=t_i with t_0=1 and t_i = AND of count[i-1:0], giving count+1 mod 2^WIDTH.
  - When the next value equals the target, go to DONE on that edge.
  - If count==target at entry to EXEC, apply hold (00) for one edge and go to DONE (zero-step command).
  - Number of EXEC edges = max(1, (target-count) mod 2^WIDTH).
- DOWN: same as UP with t_i = AND of ~count[i-1:0]. EXEC edges = max(1, (count-target) mod 2^WIDTH).
- wrapped:
  - Sticky within the command: set if an UP step goes from all-ones to 0, or a DOWN step goes from 0 to all-ones.
  - Driven out only while done=1; 0 otherwise. Always 0 for CLEAR and LOAD.
- Outside EXEC all cells receive hold (00), so count is stable in IDLE and DONE.
- No arithmetic adders: target comparison is an equality check on WIDTH bits.

Decomposition:
- Package jk_seq_pkg:
  - enum op_e {OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN} (2 bits).
  - enum state_e {S_IDLE, S_EXEC, S_DONE}.
  - localparams for the JK codes: JK_HOLD, JK_CLR, JK_SET, JK_TOG.
- Sub-module jk_cell, instantiated WIDTH times:
  - Inputs elk, reset, j, k; output q.
  - Falling edge; asynchronous active-low reset clears q.
- Top level holds the FSM, the command latch, toggle-enable generation, target compare and wrap tracking.

Test Plan (WIDTH=4):
1. Reset low mid-UP (count=5, target 12) -> count=0, busy=0, done never pulses, cmd_ready=1 immediately.
2. LOAD 0xA from IDLE -> count=0xA one edge after accept; done for one cycle with wrapped=0; cmd_ready=1 one edge later.
3. UP from 3 to 7 -> exactly 4 EXEC edges with count 4,5,6,7; done on reaching 7; wrapped=0.
4. UP from 14 to 1 -> count 15,0,1 over 3 edges; done with wrapped=1. Then DOWN from 1 to 14 -> 0,15,14; wrapped=1.
5. UP with target == current count (6) -> one EXEC edge, count stays 6, done=1, wrapped=0.
6. cmd_valid held high with a second command (CLEAR) during a running DOWN -> cmd_ready=0 until IDLE; CLEAR is accepted only after the first done; count then goes to 0.
